// File: rtl/fetch_sequencer.sv
// Multi-cycle Y86-64 fetch: reads an instruction one byte at a time from a
// variable-latency memory port and hands the assembled fields to decode.
module fetch_sequencer #(
  parameter int unsigned MEM_SIZE = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_in,
  input  logic        pc_load,
  output logic        busy,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic        instr_valid,
  output logic        imem_error,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  localparam logic [63:0] LIMIT = 64'(MEM_SIZE);

  state_t      state, state_n;
  logic [63:0] pc, pc_n;
  logic [3:0]  k, k_n, len, len_n;
  logic        busy_n, req_n, ov_n, iv_n, err_n;
  logic [63:0] addr_n, valc_n, valp_n;
  logic [3:0]  icode_n, ifun_n, ra_n, rb_n;
  logic [3:0]  cur_len, k_inc;
  logic [2:0]  vidx;
  logic [63:0] next_addr;
  logic        start;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
      4'h3, 4'h4, 4'h5:       return 4'd10;
      4'h7, 4'h8:             return 4'd9;
      default:                return 4'd1;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    pc_n    = pc;
    k_n     = k;
    len_n   = len;
    busy_n  = busy;
    req_n   = mem_req;
    addr_n  = mem_addr;
    ov_n    = out_valid;
    icode_n = icode;
    ifun_n  = ifun;
    ra_n    = rA;
    rb_n    = rB;
    valc_n  = valC;
    valp_n  = valP;
    iv_n    = instr_valid;
    err_n   = imem_error;
    start   = 1'b0;
    // Length is known from byte 0 in the very cycle it arrives.
    cur_len   = (k == 4'd0) ? instr_len(mem_rdata[7:4]) : len;
    k_inc     = k + 4'd1;
    next_addr = pc + {60'd0, k_inc};
    vidx      = k[2:0] - ((len == 4'd10) ? 3'd2 : 3'd1);

    case (state)
      IDLE: start = pc_load;
      FETCH: begin
        if (mem_ack) begin
          k_n = k_inc;
          if (k == 4'd0) begin
            icode_n = mem_rdata[7:4];
            ifun_n  = mem_rdata[3:0];
            len_n   = cur_len;
            iv_n    = (mem_rdata[7:4] < 4'hC);
            valp_n  = pc + {60'd0, cur_len};
          end else if (k == 4'd1 && (len == 4'd2 || len == 4'd10)) begin
            ra_n = mem_rdata[7:4];
            rb_n = mem_rdata[3:0];
          end else if (len >= 4'd9) begin
            valc_n[{vidx, 3'b000} +: 8] = mem_rdata;
          end
          if (k_inc == cur_len) begin
            state_n = DONE;
            req_n   = 1'b0;
            ov_n    = 1'b1;
          end else if (next_addr >= LIMIT) begin
            state_n = DONE;
            req_n   = 1'b0;
            ov_n    = 1'b1;
            err_n   = 1'b1;
          end else begin
            addr_n = next_addr;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
          ov_n    = 1'b0;
          busy_n  = 1'b0;
          start   = pc_load;
        end
      end
      default: state_n = IDLE;
    endcase

    // Shared by IDLE and the DONE handshake so back-to-back fetches lose no cycle.
    if (start) begin
      busy_n = 1'b1;
      ra_n   = 4'hF;
      rb_n   = 4'hF;
      valc_n = 64'd0;
      if (pc_in < LIMIT) begin
        state_n = FETCH;
        pc_n    = pc_in;
        k_n     = 4'd0;
        req_n   = 1'b1;
        addr_n  = pc_in;
        ov_n    = 1'b0;
        icode_n = 4'h0;
        ifun_n  = 4'h0;
        iv_n    = 1'b0;
        err_n   = 1'b0;
      end else begin
        state_n = DONE;
        req_n   = 1'b0;
        ov_n    = 1'b1;
        icode_n = 4'h1;
        ifun_n  = 4'h0;
        valp_n  = pc_in + 64'd1;
        iv_n    = 1'b1;
        err_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= 64'd0;
      k           <= 4'd0;
      len         <= 4'd0;
      busy        <= 1'b0;
      mem_req     <= 1'b0;
      mem_addr    <= 64'd0;
      out_valid   <= 1'b0;
      icode       <= 4'h0;
      ifun        <= 4'h0;
      rA          <= 4'hF;
      rB          <= 4'hF;
      valC        <= 64'd0;
      valP        <= 64'd0;
      instr_valid <= 1'b0;
      imem_error  <= 1'b0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      k           <= k_n;
      len         <= len_n;
      busy        <= busy_n;
      mem_req     <= req_n;
      mem_addr    <= addr_n;
      out_valid   <= ov_n;
      icode       <= icode_n;
      ifun        <= ifun_n;
      rA          <= ra_n;
      rB          <= rb_n;
      valC        <= valc_n;
      valP        <= valp_n;
      instr_valid <= iv_n;
      imem_error  <= err_n;
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed cases plus randomized fetches checked
// against a byte-array reference model of the instruction format.
module tb_fetch_sequencer;
  localparam int MEM_SIZE = 4096;

  logic        clk = 1'b0;
  logic        rst, pc_load, mem_ack, out_ready;
  logic [63:0] pc_in;
  logic [7:0]  mem_rdata;
  logic        busy, mem_req, instr_valid, imem_error, out_valid;
  logic [63:0] mem_addr, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;

  logic [7:0] mem [MEM_SIZE];
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic        iv, err;
    logic [3:0]  n;
  } exp_t;

  fetch_sequencer #(.MEM_SIZE(MEM_SIZE)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .pc_load(pc_load), .busy(busy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .imem_error(imem_error), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ilen(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       return 1;
      4'h2, 4'h6, 4'hA, 4'hB: return 2;
      4'h3, 4'h4, 4'h5:       return 10;
      4'h7, 4'h8:             return 9;
      default:                return 1;
    endcase
  endfunction

  // Expected result straight from the instruction format and memory contents.
  function automatic exp_t model(input logic [63:0] pc);
    exp_t e;
    int L, avail, n, first, p;
    logic [7:0] b0, b1;
    e = '0;
    e.ra = 4'hF;
    e.rb = 4'hF;
    if (pc >= 64'(MEM_SIZE)) begin
      e.icode = 4'h1;
      e.valp  = pc + 64'd1;
      e.iv    = 1'b1;
      e.err   = 1'b1;
      return e;
    end
    p     = int'(pc[11:0]);
    b0    = mem[p];
    L     = ilen(b0[7:4]);
    avail = MEM_SIZE - p;
    n     = (L < avail) ? L : avail;
    e.icode = b0[7:4];
    e.ifun  = b0[3:0];
    e.iv    = (b0[7:4] < 4'hC);
    e.err   = (n < L);
    e.valp  = pc + 64'(L);
    e.n     = 4'(n);
    if ((L == 2 || L == 10) && n >= 2) begin
      b1 = mem[p + 1];
      e.ra = b1[7:4];
      e.rb = b1[3:0];
    end
    first = (L == 10) ? 2 : 1;
    if (L >= 9)
      for (int j = 0; j < 8; j++)
        if (first + j < n) e.valc[8*j +: 8] = mem[p + first + j];
    return e;
  endfunction

  task automatic check_fields(input exp_t e);
    chk("out_valid", out_valid, 1);
    chk("icode", icode, e.icode);
    chk("ifun", ifun, e.ifun);
    chk("rA", rA, e.ra);
    chk("rB", rB, e.rb);
    chk("valC", valC, e.valc);
    chk("valP", valP, e.valp);
    chk("instr_valid", instr_valid, e.iv);
    chk("imem_error", imem_error, e.err);
    chk("busy", busy, 1);
  endtask

  task automatic launch(input logic [63:0] pc);
    @(negedge clk);
    pc_in = pc; pc_load = 1; out_ready = 0;
    @(posedge clk);
  endtask

  // Called right after the edge that accepted pc_load; serves memory with wt wait cycles.
  task automatic collect(input logic [63:0] pc, input int wt, output exp_t e);
    int cyc, nreq, w;
    logic [63:0] ea;
    e = model(pc);
    @(negedge clk);
    pc_load = 0; out_ready = 0; pc_in = 64'($urandom);
    cyc = 1; nreq = 0; w = 0;
    while (!out_valid && cyc < 400) begin
      mem_ack = 0;
      if (mem_req) begin
        ea = pc + 64'(nreq);
        chk("mem_addr", mem_addr, ea);
        if (w == wt) begin
          mem_ack = 1; mem_rdata = mem[ea[11:0]]; nreq++; w = 0;
        end else begin
          mem_rdata = 8'($urandom); w++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    mem_ack = 0;
    chk("done_cycle", 64'(cyc), 64'(int'(e.n) * (wt + 1) + 1));
    chk("bytes_fetched", 64'(nreq), 64'(e.n));
    chk("done_mem_req", mem_req, 0);
    check_fields(e);
  endtask

  // Backpressure with pc_load pulsing (must be ignored), then release.
  task automatic handshake(input exp_t e, input int hold, input bit chain, input logic [63:0] npc);
    for (int i = 0; i < hold; i++) begin
      pc_load = 1; pc_in = 64'h20; out_ready = 0;
      @(negedge clk);
      chk("hold_mem_req", mem_req, 0);
      check_fields(e);
    end
    out_ready = 1;
    pc_load   = chain;
    pc_in     = npc;
    if (chain) begin
      @(posedge clk);
    end else begin
      @(negedge clk);
      out_ready = 0; pc_load = 0;
      chk("idle_out_valid", out_valid, 0);
      chk("idle_busy", busy, 0);
      chk("idle_mem_req", mem_req, 0);
    end
  endtask

  initial begin
    exp_t e;
    logic [63:0] rpc;
    int wt;
    logic [7:0] irm [10];
    rst = 1; pc_load = 0; mem_ack = 0; out_ready = 0; pc_in = 0; mem_rdata = 0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
    irm = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};

    // reset values, with a stray ack that must be ignored
    mem_ack = 1;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_icode_ifun", {icode, ifun}, 8'h00);
    chk("rst_rA_rB", {rA, rB}, 8'hFF);
    chk("rst_valC", valC, 0);
    chk("rst_valP", valP, 0);
    chk("rst_iv_err", {instr_valid, imem_error}, 2'b00);
    rst = 0;
    @(negedge clk);
    mem_ack = 0;
    chk("post_rst_mem_req", mem_req, 0);

    // halt at 0
    mem[0] = 8'h00;
    launch(64'h0); collect(64'h0, 0, e); handshake(e, 0, 0, 0);
    // irmovq at 0x10
    for (int j = 0; j < 10; j++) mem[16 + j] = irm[j];
    launch(64'h10); collect(64'h10, 0, e);
    chk("irmovq_valC", valC, 64'h0102030405060708);
    chk("irmovq_valP", valP, 64'h1A);
    handshake(e, 0, 0, 0);
    // jmp at 0x40 with two wait cycles per byte
    mem[64] = 8'h70; mem[65] = 8'h20;
    for (int j = 2; j < 9; j++) mem[64 + j] = 8'h00;
    launch(64'h40); collect(64'h40, 2, e);
    chk("jmp_valC", valC, 64'h20);
    chk("jmp_valP", valP, 64'h49);
    handshake(e, 0, 0, 0);
    // out-of-range start addresses, including valP wrap
    launch(64'd4096); collect(64'd4096, 0, e);
    chk("oor_valP", valP, 64'd4097);
    handshake(e, 1, 0, 0);
    launch('1); collect('1, 0, e);
    chk("oor_wrap_valP", valP, 64'd0);
    handshake(e, 0, 0, 0);
    // irmovq truncated by the end of memory
    for (int j = 0; j < 6; j++) mem[4090 + j] = irm[j];
    launch(64'd4090); collect(64'd4090, 1, e);
    chk("trunc_valC", valC, 64'h05060708);
    chk("trunc_valP", valP, 64'd4100);
    chk("trunc_err", imem_error, 1);
    handshake(e, 0, 0, 0);
    // invalid icode, backpressure, then chained start
    mem[512] = 8'hD5;
    launch(64'h200); collect(64'h200, 1, e);
    chk("inv_iv", instr_valid, 0);
    chk("inv_valP", valP, 64'h201);
    handshake(e, 5, 1, 64'h10);
    collect(64'h10, 0, e); handshake(e, 0, 0, 0);

    // reset during the 4th byte of an mrmovq
    mem[768] = 8'h50; mem[769] = 8'h12;
    launch(64'h300);
    @(negedge clk);
    pc_load = 0;
    for (int c = 0; c < 3; c++) begin
      mem_ack = 1; mem_rdata = mem[768 + c];
      @(negedge clk);
    end
    chk("mid_rst_addr", mem_addr, 64'h303);
    chk("mid_rst_req", mem_req, 1);
    rst = 1; mem_ack = 0;
    @(negedge clk);
    chk("mid_rst_req_low", mem_req, 0);
    chk("mid_rst_ov", out_valid, 0);
    chk("mid_rst_rArB", {rA, rB}, 8'hFF);
    chk("mid_rst_busy", busy, 0);
    rst = 0; mem_ack = 1; mem_rdata = 8'h55;
    @(negedge clk);
    mem_ack = 0;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_ov", out_valid, 0);
    chk("late_ack_icode", icode, 0);
    chk("late_ack_valC", valC, 0);

    // randomized fetches
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0:       rpc = 64'(MEM_SIZE - int'($urandom_range(1, 12)));
        1:       rpc = 64'(MEM_SIZE + int'($urandom_range(0, 50)));
        default: rpc = 64'($urandom_range(0, MEM_SIZE - 1));
      endcase
      wt = int'($urandom_range(0, 3));
      launch(rpc); collect(rpc, wt, e);
      handshake(e, int'($urandom_range(0, 3)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
